uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter paced by a 16x oversampling tick; pulls one word per frame from an
// upstream FIFO and sends start, DATA_SIZE data bits LSB first, optional parity, stop.
module uart_tx #(
  parameter int DATA_SIZE  = 8,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [4:0] LAST_TICK = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(STOP_TICKS - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_SIZE - 1);

  state_e               state_q, state_d;
  logic [4:0]           tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 tick_end;
  logic                 advance;

  // fifo_data is only valid in the strobe cycle, so the load below happens on that same edge.
  assign fifo_rd      = (state_q == IDLE) && !fifo_empty && !reset;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    tick_end = (state_q == STOP) ? (tick_q == STOP_LAST) : (tick_q == LAST_TICK);
    advance  = sample_tick && tick_end;

    if (state_q != IDLE && sample_tick) begin
      tick_d = tick_end ? 5'd0 : tick_q + 5'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (fifo_rd) begin
          shreg_d  = fifo_data;
          parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
          tick_d   = 5'd0;
          bit_d    = 3'd0;
          state_d  = START;
        end
      end
      START: if (advance) state_d = DATA;
      DATA: begin
        if (advance) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: if (advance) state_d = STOP;
      STOP: begin
        if (advance) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is decoded from the next state so the registered line changes on the state edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= 5'd0;
      bit_q    <= 3'd0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E with 2 stop bits, 8O1) fed by FIFO models;
// frames are decoded from tx and compared against a scoreboard of queued words.
module tb_uart_tx;

  typedef struct {
    int         k;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick;
  logic [2:0] fifo_empty, fifo_rd, tx, tx_busy, tx_done_tick;
  logic [7:0] fifo_data [3];

  logic [7:0] mem [3][16];
  logic [3:0] wr_ptr [3];
  logic [3:0] rd_ptr [3];
  logic [2:0] rd_seen, tx_prev, busy_prev, busy_before;
  int         rd_count [3], done_count [3], rd_cyc [3], done_cyc [3], last_edge [3];
  int         edge0 [32];
  int         n_edge0 = 0;
  int         cyc = 0;
  int         tick_div = 4;
  bit         tick_en = 1'b1;
  exp_t       sb [$];
  int         tests = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign fifo_empty[g] = (wr_ptr[g] == rd_ptr[g]);
    assign fifo_data[g]  = mem[g][rd_ptr[g]];
  end

  uart_tx #(.DATA_SIZE(8), .STOP_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]), .tx_busy(tx_busy[0]),
    .tx_done_tick(tx_done_tick[0]));

  uart_tx #(.DATA_SIZE(8), .STOP_TICKS(32), .PARITY_EN(1), .PARITY_ODD(0)) u_8e2 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]), .tx_busy(tx_busy[1]),
    .tx_done_tick(tx_done_tick[1]));

  uart_tx #(.DATA_SIZE(8), .STOP_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .fifo_empty(fifo_empty[2]),
    .fifo_data(fifo_data[2]), .fifo_rd(fifo_rd[2]), .tx(tx[2]), .tx_busy(tx_busy[2]),
    .tx_done_tick(tx_done_tick[2]));

  // A read strobe seen at a rising edge pops the FIFO model at the following falling edge.
  always @(posedge clk) rd_seen <= fifo_rd;

  always @(negedge clk) begin
    cyc         <= cyc + 1;
    sample_tick <= tick_en && (((cyc + 1) % tick_div) == 0);
    for (int k = 0; k < 3; k++) begin
      if (rd_seen[k]) begin
        rd_ptr[k]   <= rd_ptr[k] + 4'd1;
        rd_count[k] <= rd_count[k] + 1;
        rd_cyc[k]   <= cyc;
      end
      if (tx_done_tick[k]) begin
        done_count[k]  <= done_count[k] + 1;
        done_cyc[k]    <= cyc;
        busy_before[k] <= busy_prev[k];
      end
      if (tx[k] !== tx_prev[k]) last_edge[k] <= cyc;
    end
    if (tx[0] !== tx_prev[0] && n_edge0 < 32) begin
      edge0[n_edge0] <= cyc;
      n_edge0        <= n_edge0 + 1;
    end
    tx_prev   <= tx;
    busy_prev <= tx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input bit score);
    exp_t e;
    mem[k][wr_ptr[k]] = d;
    wr_ptr[k] = wr_ptr[k] + 4'd1;
    if (score) begin
      e.k    = k;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  // Waits for a start bit on instance k, samples every bit mid-period, checks it against
  // the scoreboard, then waits for the done pulse.
  task automatic rx_frame(input int k);
    int          n, t0, nb, bit_clks;
    logic [10:0] bits;
    exp_t        e;
    bit_clks = 16 * tick_div;
    nb = (k == 0) ? 10 : 11;
    bits = '0;
    n = 0;
    while (tx[k] !== 1'b0 && n < 4000) begin
      step();
      n++;
    end
    check("start_seen", tx[k], 1'b0);
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      while (cyc < t0 + bit_clks / 2 + bit_clks * i) step();
      bits[i] = tx[k];
    end
    check("sb_pending", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.k    = -1;
      e.data = 8'h00;
    end
    check("sb_inst", e.k, k);
    check("start_bit", bits[0], 1'b0);
    check("data_bits", bits[8:1], e.data);
    if (k != 0) check("parity_bit", bits[9], (^e.data) ^ (k == 2));
    check("stop_bit", bits[nb-1], 1'b1);
    n = 0;
    while (tx_done_tick[k] !== 1'b1 && n < 3 * bit_clks) begin
      step();
      n++;
    end
    check("done_pulse", tx_done_tick[k], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0, dn0, e0, viol, n, t0;
    for (int k = 0; k < 3; k++) begin
      wr_ptr[k] = 4'd0;
      rd_ptr[k] = 4'd0;
    end

    // Reset state, with a word already waiting in the FIFO of instance 0.
    reset = 1'b1;
    send(0, 8'h55, 1'b1);
    step(3);
    check("rst_tx", tx, 3'b111);
    check("rst_busy", tx_busy, 3'b000);
    check("rst_done", tx_done_tick, 3'b000);
    check("rst_fifo_rd", fifo_rd, 3'b000);
    e0 = n_edge0;
    reset = 1'b0;

    // 8N1, 0x55, tick every 4 clks: alternating bits of 64 clks each.
    rx_frame(0);
    check("rd_pulses_55", rd_count[0], 1);
    check("edges_55", n_edge0 - e0, 10);
    for (int i = 1; i <= 8; i++) check("bit_len_55", edge0[e0+i+1] - edge0[e0+i], 64);
    check("stop_len_55", done_cyc[0] - edge0[e0+9], 64);
    step();
    check("done_one_clk", tx_done_tick[0], 1'b0);
    check("done_count_55", done_count[0], 1);

    // Three preloaded words go out back to back with one idle clk between frames.
    rd0 = rd_count[0];
    dn0 = done_count[0];
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b1);
    send(0, 8'hFF, 1'b1);
    for (int f = 0; f < 3; f++) begin
      rx_frame(0);
      check("busy_at_done", tx_busy[0], 1'b0);
      if (f < 2) begin
        check("gap_fetch", fifo_rd[0], 1'b1);
        check("gap_idle_tx", tx[0], 1'b1);
        step();
        check("gap_next_start", tx[0], 1'b0);
      end
    end
    step();
    check("rd_pulses_3", rd_count[0] - rd0, 3);
    check("done_count_3", done_count[0] - dn0, 3);

    // Even parity with a 32-tick stop, then odd parity with a 16-tick stop.
    send(1, 8'h07, 1'b1);
    rx_frame(1);
    send(1, 8'h03, 1'b1);
    rx_frame(1);
    check("stop32_len", done_cyc[1] - last_edge[1], 128);
    check("busy_before_done", busy_before[1], 1'b1);
    check("busy_at_done32", tx_busy[1], 1'b0);
    send(2, 8'h07, 1'b1);
    rx_frame(2);
    check("stop16_odd_len", done_cyc[2] - last_edge[2], 64);

    // sample_tick high every clk: frame lasts exactly its tick count in clks.
    tick_div = 1;
    step(2);
    send(0, 8'hC3, 1'b1);
    rx_frame(0);
    check("frame_len_tick1", done_cyc[0] - rd_cyc[0], 160);
    tick_div = 4;

    // No ticks: the fetch still happens, then the FSM freezes in START.
    tick_en = 1'b0;
    step(2);
    rd0 = rd_count[0];
    dn0 = done_count[0];
    send(0, 8'h81, 1'b0);
    step(2);
    check("frozen_fetch", rd_count[0] - rd0, 1);
    check("frozen_tx", tx[0], 1'b0);
    step(50);
    check("frozen_hold_tx", tx[0], 1'b0);
    check("frozen_busy", tx_busy[0], 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_tx", tx[0], 1'b1);
    check("async_rst_busy", tx_busy[0], 1'b0);
    step(2);
    reset = 1'b0;
    tick_en = 1'b1;
    step(2);

    // Reset during data bit 3, then a long idle stretch with an empty FIFO.
    rd0 = rd_count[0];
    dn0 = done_count[0];
    send(0, 8'h00, 1'b0);
    n = 0;
    while (tx[0] !== 1'b0 && n < 4000) begin
      step();
      n++;
    end
    check("rst_frame_start", tx[0], 1'b0);
    t0 = cyc;
    while (cyc < t0 + 32 + 64 * 4) step();
    check("bit3_tx", tx[0], 1'b0);
    check("bit3_busy", tx_busy[0], 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx[0], 1'b1);
    check("mid_rst_busy", tx_busy[0], 1'b0);
    check("mid_rst_fifo_rd", fifo_rd[0], 1'b0);
    check("mid_rst_done", tx_done_tick[0], 1'b0);
    step(3);
    reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (fifo_rd[0] !== 1'b0 || tx[0] !== 1'b1 || tx_busy[0] !== 1'b0) viol++;
    end
    check("idle_violations", viol, 0);
    check("idle_rd_count", rd_count[0] - rd0, 1);
    check("no_done_after_rst", done_count[0] - dn0, 0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
